// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for if_id_queue.
// master drives fetch responses, flush and decode stall; slave is the queue.
interface if_id_queue_if;
  logic        f_done;
  logic        f_stall;
  logic [15:0] f_instr;
  logic [15:0] f_pc2;
  logic        f_err;
  logic        flush;
  logic        d_stall;
  logic        d_valid;
  logic [15:0] d_instr;
  logic [15:0] d_pc2;
  logic        d_err;
  logic        q_full;
  logic        saved_flush;

  modport master (
    output f_done, f_stall, f_instr, f_pc2, f_err, flush, d_stall,
    input  d_valid, d_instr, d_pc2, d_err, q_full, saved_flush
  );

  modport slave (
    input  f_done, f_stall, f_instr, f_pc2, f_err, flush, d_stall,
    output d_valid, d_instr, d_pc2, d_err, q_full, saved_flush
  );
endinterface

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode, with flush and in-flight-response drop.
// Define IFQ_BYPASS_EN to let a fetch response pass an empty queue straight to decode.
module if_id_queue #(
  parameter int          DEPTH     = 2,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input logic         clk,
  input logic         rst,
  if_id_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        err;
  } entry_t;

  typedef enum logic {IDLE = 1'b0, DROP = 1'b1} state_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;

  logic empty;
  logic full;
  logic push_en;
  logic store_en;
  logic pop_en;
  logic bypass;

  assign empty           = (count == '0);
  assign full            = (count == CW'(DEPTH));
  assign bus.q_full      = full;
  assign bus.saved_flush = (state == DROP);

  assign push_en = bus.f_done & ~full & ~bus.flush & (state == IDLE);
`ifdef IFQ_BYPASS_EN
  // An empty queue with a willing decoder hands the response over directly.
  assign bypass = empty & push_en & ~bus.d_stall;
`else
  assign bypass = 1'b0;
`endif
  assign store_en = push_en & ~bypass;
  assign pop_en   = ~empty & ~bus.d_stall & ~bus.flush;

  // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    bus.d_valid = 1'b0;
    bus.d_instr = NOP_INSTR;
    bus.d_pc2   = '0;
    bus.d_err   = 1'b0;
    if (!empty) begin
      bus.d_valid = 1'b1;
      bus.d_instr = mem[rd_ptr].instr;
      bus.d_pc2   = mem[rd_ptr].pc2;
      bus.d_err   = mem[rd_ptr].err;
    end else if (bypass) begin
      bus.d_valid = 1'b1;
      bus.d_instr = bus.f_instr;
      bus.d_pc2   = bus.f_pc2;
      bus.d_err   = bus.f_err;
    end
  end

  // NOTE: storage is not reset; count gates visibility so stale entries are never shown.
  always_ff @(posedge clk) begin
    if (store_en) mem[wr_ptr] <= '{instr: bus.f_instr, pc2: bus.f_pc2, err: bus.f_err};
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= IDLE;
    end else begin
      if (bus.flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (store_en) wr_ptr <= wr_ptr + AW'(1);
        if (pop_en)   rd_ptr <= rd_ptr + AW'(1);
        if (store_en && !pop_en)      count <= count + CW'(1);
        else if (!store_en && pop_en) count <= count - CW'(1);
      end

      // DROP swallows the one response still owed for a request killed by flush.
      case (state)
        IDLE: if (bus.flush && bus.f_stall && !bus.f_done) state <= DROP;
        DROP: if (!bus.flush && bus.f_done)                state <= IDLE;
        default:                                           state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 2: number of queue entries; legal values 2 and 4.
REQ-002 Parameter NOP_INSTR, default 16'h0800: instruction driven on d_instr when the queue is empty.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port f_done, input, 1: fetch memory returns a valid instruction this cycle.
REQ-006 Port f_stall, input, 1: fetch memory request outstanding (busy).
REQ-007 Port f_instr, input, 16: fetched instruction.
REQ-008 Port f_pc2, input, 16: address of the fetched instruction plus 2.
REQ-009 Port f_err, input, 1: fetch memory error flag for this instruction.
REQ-010 Port flush, input, 1: redirect from a later stage; discard all queued and in-flight instructions.
REQ-011 Port d_stall, input, 1: decode cannot accept an instruction this cycle.
REQ-012 Port d_valid, output, 1: d_instr, d_pc2 and d_err are valid.
REQ-013 Port d_instr, output, 16: instruction to decode.
REQ-014 Port d_pc2, output, 16: PC+2 of d_instr.
REQ-015 Port d_err, output, 1: fetch error attached to d_instr.
REQ-016 Port q_full, output, 1: queue full; fetch holds its PC.
REQ-017 Port saved_flush, output, 1: a flushed fetch response is still outstanding; fetch holds its PC.

Function
REQ-018 The block SHALL implement a FIFO of DEPTH entries, each holding {instr, pc2, err}, with a count from 0 to DEPTH and read/write pointers that wrap modulo DEPTH.
REQ-019 A push SHALL occur when f_done=1, q_full=0, flush=0 and state=IDLE.
REQ-020 A pop SHALL occur when d_valid=1, d_stall=0 and flush=0.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-022 q_full SHALL equal (count==DEPTH); a push is blocked while q_full=1, even if a pop occurs in the same cycle.
REQ-023 d_valid SHALL equal (count!=0); d_instr, d_pc2 and d_err SHALL show the head entry.
REQ-024 When count==0, d_instr SHALL be NOP_INSTR, d_pc2 SHALL be 0 and d_err SHALL be 0.
REQ-025 Latency: an instruction pushed at edge N SHALL appear on d_* in the cycle after edge N (one cycle).
REQ-026 The state machine SHALL have two states: IDLE and DROP.
REQ-027 On flush=1, the next edge SHALL set count to 0 and both pointers to 0, and any f_done in that cycle SHALL be discarded.
REQ-028 Transition IDLE->DROP SHALL occur when flush=1, f_stall=1 and f_done=0.
REQ-029 In DROP, the next f_done SHALL be discarded and the state SHALL return to IDLE.
REQ-030 flush=1 while in DROP SHALL keep the state in DROP.
REQ-031 saved_flush SHALL equal (state==DROP).
REQ-032 flush=1 together with f_done=1 SHALL discard the response and leave the state in IDLE.
REQ-033 f_err SHALL be queued and delivered unchanged, in order, and SHALL NOT affect queue control.

Reset
REQ-034 With rst=1 at an edge, the block SHALL set count=0, both pointers=0 and state=IDLE.
REQ-035 After that edge the outputs SHALL be d_valid=0, d_instr=NOP_INSTR, d_pc2=0, d_err=0, q_full=0 and saved_flush=0.
REQ-036 rst SHALL override flush, push and pop in the same cycle, including in DROP.

Configuration
REQ-037 Macro IFQ_BYPASS_EN SHALL control whether an instruction can bypass the empty queue.
REQ-038 With IFQ_BYPASS_EN defined, when count==0, a push qualifies and d_stall=0:
- f_instr, f_pc2 and f_err SHALL drive d_* combinationally in the same cycle, with d_valid=1;
- the entry SHALL NOT be stored, so count stays 0 (zero latency).
REQ-039 With IFQ_BYPASS_EN not defined, outputs SHALL be driven only from queue storage, with the one-cycle latency of REQ-025.

Verification
REQ-040 Reset, then f_done=1, f_instr=16'h1234, f_pc2=16'h0002, d_stall=0 for 1 cycle -> next cycle d_valid=1, d_instr=16'h1234, d_pc2=16'h0002; the cycle after, d_valid=0 and d_instr=16'h0800.
REQ-041 d_stall=1; push 16'hA001 then 16'hA002 -> q_full=1; a third push of 16'hA003 is dropped; after d_stall=0, decode sees A001 then A002 only.
REQ-042 Queue holds 2 entries; flush=1 with f_stall=1, f_done=0 -> next cycle count=0, d_valid=0, saved_flush=1; then f_done=1 with 16'hBEEF -> BEEF discarded and saved_flush=0 in the next cycle.
REQ-043 flush=1 and f_done=1 (16'hC0DE) in the same cycle -> C0DE never appears on d_instr and saved_flush stays 0.
REQ-044 Ten back-to-back pushes with alternating d_stall -> all ten delivered in order with no loss or duplication through pointer wrap; f_err=1 on the 5th push -> d_err=1 only on the 5th delivered instruction.
REQ-045 With IFQ_BYPASS_EN defined and the queue empty, f_done=1 with 16'h7777 and d_stall=0 -> d_valid=1 and d_instr=16'h7777 in the same cycle, with count remaining 0.
